// File: rtl/tape_player.sv
// Tape playback engine: fetches an image byte by byte from memory and
// serialises it MSB first as a biphase signal (each bit is ~b then b, one
// half-cell each). The next byte is prefetched into a one-byte buffer so
// consecutive bytes play without a gap; a late fetch stalls the output and
// raises the sticky underrun flag.
module tape_player #(
  parameter int unsigned HALF_CELL = 8000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [23:0] size,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        tape_out,
  output logic        active,
  output logic        done,
  output logic        underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH0, ST_PLAY} state_t;

  localparam logic [15:0] LP_CELL_LAST = 16'(HALF_CELL - 1);

  state_t      r_state;
  logic [23:0] r_len;
  logic [23:0] r_addr;
  logic        r_rd;
  logic        r_all_fetched;
  logic [7:0]  r_shift;
  logic [7:0]  r_buf;
  logic        r_buf_full;
  logic [2:0]  r_bit;
  logic        r_half;
  logic [15:0] r_cnt;
  logic        r_stall;
  logic        r_tape;
  logic        r_active;
  logic        r_done;
  logic        r_underrun;

  logic        w_cell_end;
  logic        w_byte_end;
  logic        w_last_addr;
  logic        w_direct;
  logic        w_load;
  logic [7:0]  w_load_data;

  // Cell/byte boundary decode and selection of the next byte source
  always_comb begin
    w_cell_end  = (r_cnt == LP_CELL_LAST);
    w_byte_end  = w_cell_end && r_half && (r_bit == 3'd0);
    w_last_addr = (r_addr == r_len - 24'd1);
    // A fetch completing exactly when the next byte is needed bypasses the buffer
    w_direct    = mem_ready && r_rd && !pause && !r_buf_full && (r_stall || w_byte_end);
    w_load      = r_buf_full || w_direct;
    w_load_data = r_buf_full ? r_buf : mem_data;
  end

  // Playback FSM: fetch control, prefetch buffer and biphase serialiser
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_addr        <= '0;
      r_rd          <= 1'b0;
      r_all_fetched <= 1'b0;
      r_shift       <= '0;
      r_buf         <= '0;
      r_buf_full    <= 1'b0;
      r_bit         <= '0;
      r_half        <= 1'b0;
      r_cnt         <= '0;
      r_stall       <= 1'b0;
      r_tape        <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && (r_state != ST_IDLE)) begin
        r_state    <= ST_IDLE;
        r_active   <= 1'b0;
        r_rd       <= 1'b0;
        r_tape     <= 1'b0;
        r_stall    <= 1'b0;
        r_buf_full <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop) begin
              if (size != '0) begin
                r_state       <= ST_FETCH0;
                r_active      <= 1'b1;
                r_len         <= size;
                r_addr        <= '0;
                r_rd          <= 1'b1;
                r_all_fetched <= 1'b0;
                r_buf_full    <= 1'b0;
                r_stall       <= 1'b0;
                r_underrun    <= 1'b0;
                r_cnt         <= '0;
                r_half        <= 1'b0;
                r_bit         <= 3'd7;
              end else begin
                r_done <= 1'b1;
              end
            end
          end

          ST_FETCH0: begin
            if (mem_ready) begin
              r_state <= ST_PLAY;
              r_rd    <= 1'b0;
              r_shift <= mem_data;
              r_bit   <= 3'd7;
              r_half  <= 1'b0;
              r_cnt   <= '0;
              r_tape  <= ~mem_data[7];
              if (w_last_addr) r_all_fetched <= 1'b1;
              else             r_addr        <= r_addr + 24'd1;
            end
          end

          ST_PLAY: begin
            // Fetch side runs even while paused so the buffer can fill.
            // The address saturates at the last byte so it never reaches len.
            if (mem_ready && r_rd) begin
              r_rd <= 1'b0;
              if (w_last_addr) r_all_fetched <= 1'b1;
              else             r_addr        <= r_addr + 24'd1;
              if (!w_direct) begin
                r_buf      <= mem_data;
                r_buf_full <= 1'b1;
              end
            end else if (!r_rd && !r_buf_full && !r_all_fetched) begin
              r_rd <= 1'b1;
            end

            if (!pause) begin
              if (r_stall) begin
                if (w_load) begin
                  r_stall    <= 1'b0;
                  r_shift    <= w_load_data;
                  r_buf_full <= 1'b0;
                  r_bit      <= 3'd7;
                  r_half     <= 1'b0;
                  r_cnt      <= '0;
                  r_tape     <= ~w_load_data[7];
                end
              end else if (w_cell_end) begin
                if (!r_half) begin
                  r_half <= 1'b1;
                  r_cnt  <= '0;
                  r_tape <= r_shift[r_bit];
                end else if (r_bit != 3'd0) begin
                  r_bit  <= r_bit - 3'd1;
                  r_half <= 1'b0;
                  r_cnt  <= '0;
                  r_tape <= ~r_shift[r_bit - 3'd1];
                end else if (w_load) begin
                  r_shift    <= w_load_data;
                  r_buf_full <= 1'b0;
                  r_bit      <= 3'd7;
                  r_half     <= 1'b0;
                  r_cnt      <= '0;
                  r_tape     <= ~w_load_data[7];
                end else if (r_rd) begin
                  r_stall    <= 1'b1;
                  r_underrun <= 1'b1;
                end else begin
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
                  r_done   <= 1'b1;
                  r_tape   <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_rd   = r_rd;
  assign tape_out = r_tape;
  assign active   = r_active;
  assign done     = r_done;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_tape_player.sv
// Directed testbench for tape_player with HALF_CELL=4 and a latency-
// programmable memory responder.
module tb_tape_player;

  localparam int unsigned HC = 4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        pause;
  logic [23:0] size;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        tape_out;
  logic        active;
  logic        done;
  logic        underrun;

  tape_player #(.HALF_CELL(HC)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .size      (size),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .tape_out  (tape_out),
    .active    (active),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  mem [0:255];
  int          base_lat = 0;
  int          slow_idx = -1;
  int          slow_lat = 0;
  int          req_idx  = 0;
  int          wait_cnt = 0;
  logic [23:0] fetch_log [$];

  logic        cap_tape [$];
  logic        cap_done [$];
  logic        cap_rd   [$];
  logic        cap_und  [$];
  logic [23:0] cap_addr [$];
  logic        exp_wave [$];

  int pause_at = -1;
  int stop_at  = -1;
  int start_at = -1;

  // Memory responder: acknowledges a held request after a programmable wait
  initial begin
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk_sys);
      mem_ready = 1'b0;
      if (mem_rd) begin
        if (wait_cnt >= ((req_idx == slow_idx) ? slow_lat : base_lat)) begin
          mem_ready = 1'b1;
          mem_data  = mem[mem_addr[7:0]];
          fetch_log.push_back(mem_addr);
          req_idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Reference biphase waveform of one byte, MSB first
  function automatic void add_byte(input logic [7:0] b);
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < HC; j++) exp_wave.push_back(~b[3'(7 - i)]);
      for (int unsigned j = 0; j < HC; j++) exp_wave.push_back(b[3'(7 - i)]);
    end
  endfunction

  function automatic void add_level(input logic v, input int unsigned n);
    for (int unsigned j = 0; j < n; j++) exp_wave.push_back(v);
  endfunction

  // Start a playback and record one sample per cycle until active drops
  task automatic play(input logic [23:0] sz, input int budget, output bit timed_out);
    int k;
    cap_tape.delete(); cap_done.delete(); cap_rd.delete();
    cap_und.delete();  cap_addr.delete(); fetch_log.delete();
    req_idx   = 0;
    timed_out = 1'b0;
    @(negedge clk_sys);
    start = 1'b1;
    size  = sz;
    @(negedge clk_sys);
    start = 1'b0;
    k = 0;
    forever begin
      cap_tape.push_back(tape_out);
      cap_done.push_back(done);
      cap_rd.push_back(mem_rd);
      cap_und.push_back(underrun);
      cap_addr.push_back(mem_addr);
      if (!active) break;
      if (k >= budget) begin
        timed_out = 1'b1;
        break;
      end
      stop  = (k == stop_at);
      start = (k == start_at);
      pause = (pause_at >= 0) && (k >= pause_at) && (k < pause_at + 37);
      @(negedge clk_sys);
      k++;
    end
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    vectors++; if (tape_out !== 1'b0) begin errors++; $display("FAIL reset_tape got %b want 0", tape_out); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", mem_rd); end
    vectors++; if (mem_addr !== 24'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_single_byte;
    bit to;
    int last;
    int early_done;
    base_lat = 2; slow_idx = -1;
    mem[0] = 8'hA5;
    exp_wave.delete();
    add_level(1'b0, 3);
    add_byte(8'hA5);
    play(24'd1, 500, to);
    vectors++; if (to) begin errors++; $display("FAIL single_timeout got timeout want idle"); end
    vectors++;
    if (cap_tape.size() != exp_wave.size() + 1) begin
      errors++; $display("FAIL single_len got %0d want %0d", cap_tape.size(), exp_wave.size() + 1);
    end
    for (int unsigned i = 0; i < exp_wave.size() && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL single_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
    last = cap_tape.size() - 1;
    early_done = 0;
    for (int i = 0; i < last; i++) if (cap_done[i]) early_done++;
    vectors++; if (early_done != 0) begin errors++; $display("FAIL single_early_done got %0d want 0", early_done); end
    vectors++; if (cap_done[last] !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", cap_done[last]); end
    vectors++; if (cap_tape[last] !== 1'b0) begin errors++; $display("FAIL single_tape_end got %b want 0", cap_tape[last]); end
    @(negedge clk_sys);
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL single_active got %b want 0", active); end
  endtask

  task automatic test_three_bytes;
    bit to;
    int last;
    base_lat = 1; slow_idx = -1;
    mem[0] = 8'h3C; mem[1] = 8'h81; mem[2] = 8'h5E;
    exp_wave.delete();
    add_level(1'b0, 2);
    add_byte(8'h3C); add_byte(8'h81); add_byte(8'h5E);
    start_at = 50;
    play(24'd3, 1000, to);
    start_at = -1;
    vectors++; if (to) begin errors++; $display("FAIL three_timeout got timeout want idle"); end
    vectors++;
    if (cap_tape.size() != exp_wave.size() + 1) begin
      errors++; $display("FAIL three_len got %0d want %0d", cap_tape.size(), exp_wave.size() + 1);
    end
    for (int unsigned i = 0; i < exp_wave.size() && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL three_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
    last = cap_tape.size() - 1;
    vectors++; if (cap_done[last] !== 1'b1) begin errors++; $display("FAIL three_done got %b want 1", cap_done[last]); end
    vectors++; if (cap_und[last] !== 1'b0) begin errors++; $display("FAIL three_underrun got %b want 0", cap_und[last]); end
    vectors++;
    if (fetch_log.size() != 3) begin
      errors++; $display("FAIL three_fetch_count got %0d want 3", fetch_log.size());
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        vectors++;
        if (fetch_log[i] !== 24'(i)) begin
          errors++; $display("FAIL three_fetch_addr[%0d] got %0h want %0h", i, fetch_log[i], i);
        end
      end
    end
  endtask

  task automatic test_underrun;
    bit to;
    int last;
    base_lat = 0; slow_idx = 1; slow_lat = 162;
    mem[0] = 8'hC3; mem[1] = 8'h5A;
    exp_wave.delete();
    add_level(1'b0, 1);
    add_byte(8'hC3);
    add_level(1'b1, 100);
    add_byte(8'h5A);
    play(24'd2, 1000, to);
    slow_idx = -1;
    vectors++; if (to) begin errors++; $display("FAIL underrun_timeout got timeout want idle"); end
    vectors++;
    if (cap_tape.size() != exp_wave.size() + 1) begin
      errors++; $display("FAIL underrun_len got %0d want %0d", cap_tape.size(), exp_wave.size() + 1);
    end
    for (int unsigned i = 0; i < exp_wave.size() && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL underrun_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
    if (cap_und.size() > 65) begin
      vectors++; if (cap_und[64] !== 1'b0) begin errors++; $display("FAIL underrun_before got %b want 0", cap_und[64]); end
      vectors++; if (cap_und[65] !== 1'b1) begin errors++; $display("FAIL underrun_at_boundary got %b want 1", cap_und[65]); end
    end
    last = cap_tape.size() - 1;
    vectors++; if (cap_und[last] !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", cap_und[last]); end
    vectors++; if (cap_done[last] !== 1'b1) begin errors++; $display("FAIL underrun_done got %b want 1", cap_done[last]); end
  endtask

  task automatic test_pause;
    bit to;
    logic held;
    base_lat = 0; slow_idx = -1;
    mem[0] = 8'hB4;
    exp_wave.delete();
    add_level(1'b0, 1);
    add_byte(8'hB4);
    held = exp_wave[6];
    for (int unsigned j = 0; j < 37; j++) exp_wave.insert(7, held);
    pause_at = 6;
    play(24'd1, 500, to);
    pause_at = -1;
    vectors++; if (to) begin errors++; $display("FAIL pause_timeout got timeout want idle"); end
    vectors++; if (cap_und[0] !== 1'b0) begin errors++; $display("FAIL pause_underrun_cleared got %b want 0", cap_und[0]); end
    vectors++;
    if (cap_tape.size() != exp_wave.size() + 1) begin
      errors++; $display("FAIL pause_len got %0d want %0d", cap_tape.size(), exp_wave.size() + 1);
    end
    for (int unsigned i = 0; i < exp_wave.size() && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL pause_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
    vectors++; if (cap_done[cap_done.size() - 1] !== 1'b1) begin errors++; $display("FAIL pause_done got 0 want 1"); end
  endtask

  task automatic test_stop_replay;
    bit to;
    int last;
    int seen_done;
    base_lat = 0; slow_idx = -1;
    for (int unsigned i = 0; i < 8; i++) mem[i] = 8'((i * 37) + 11);
    exp_wave.delete();
    add_level(1'b0, 1);
    for (int unsigned i = 0; i < 6; i++) add_byte(mem[i]);
    // byte 5 starts at sample 321; bit 3 begins 32 samples later
    stop_at = 355;
    play(24'd8, 2000, to);
    stop_at = -1;
    vectors++; if (to) begin errors++; $display("FAIL stop_timeout got timeout want idle"); end
    vectors++; if (cap_tape.size() != 357) begin errors++; $display("FAIL stop_len got %0d want 357", cap_tape.size()); end
    for (int unsigned i = 0; i <= 355 && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL stop_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
    last = cap_tape.size() - 1;
    vectors++; if (cap_tape[last] !== 1'b0) begin errors++; $display("FAIL stop_tape got %b want 0", cap_tape[last]); end
    vectors++; if (cap_rd[last] !== 1'b0) begin errors++; $display("FAIL stop_rd got %b want 0", cap_rd[last]); end
    seen_done = cap_done[last] ? 1 : 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (done) seen_done++;
    end
    vectors++; if (seen_done != 0) begin errors++; $display("FAIL stop_no_done got %0d want 0", seen_done); end

    exp_wave.delete();
    add_level(1'b0, 1);
    add_byte(mem[0]); add_byte(mem[1]);
    play(24'd2, 1000, to);
    vectors++; if (to) begin errors++; $display("FAIL replay_timeout got timeout want idle"); end
    vectors++; if (cap_addr[0] !== 24'd0) begin errors++; $display("FAIL replay_addr got %0h want 0", cap_addr[0]); end
    vectors++; if (cap_rd[0] !== 1'b1) begin errors++; $display("FAIL replay_rd got %b want 1", cap_rd[0]); end
    vectors++; if (fetch_log.size() != 2) begin errors++; $display("FAIL replay_fetch_count got %0d want 2", fetch_log.size()); end
    vectors++;
    if (cap_tape.size() != exp_wave.size() + 1) begin
      errors++; $display("FAIL replay_len got %0d want %0d", cap_tape.size(), exp_wave.size() + 1);
    end
    for (int unsigned i = 0; i < exp_wave.size() && i < cap_tape.size(); i++) begin
      vectors++;
      if (cap_tape[i] !== exp_wave[i]) begin
        errors++; $display("FAIL replay_wave[%0d] got %b want %b", i, cap_tape[i], exp_wave[i]);
      end
    end
  endtask

  task automatic test_size_zero;
    @(negedge clk_sys);
    start = 1'b1; size = 24'd0;
    @(negedge clk_sys);
    start = 1'b0;
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL zero_active got %b want 0", active); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL zero_rd got %b want 0", mem_rd); end
    @(negedge clk_sys);
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL zero_rd_later got %b want 0", mem_rd); end
  endtask

  task automatic test_start_stop_same;
    @(negedge clk_sys);
    start = 1'b1; stop = 1'b1; size = 24'd4;
    @(negedge clk_sys);
    start = 1'b0; stop = 1'b0;
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL startstop_active got %b want 0", active); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL startstop_rd got %b want 0", mem_rd); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL startstop_done got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    base_lat = 0; slow_idx = -1;
    @(negedge clk_sys);
    start = 1'b1; size = 24'd4;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (100) @(negedge clk_sys);
    vectors++; if (active !== 1'b1) begin errors++; $display("FAIL rstmid_playing got %b want 1", active); end
    reset = 1'b1;
    #1;
    vectors++; if (tape_out !== 1'b0) begin errors++; $display("FAIL rstmid_tape got %b want 0", tape_out); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd got %b want 0", mem_rd); end
    vectors++; if (mem_addr !== 24'd0) begin errors++; $display("FAIL rstmid_addr got %0h want 0", mem_addr); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b want 0", active); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL rstmid_underrun got %b want 0", underrun); end
    @(negedge clk_sys);
    reset = 1'b0; start = 1'b1; size = 24'd2;
    @(negedge clk_sys);
    start = 1'b0;
    vectors++; if (active !== 1'b1) begin errors++; $display("FAIL rstmid_restart_active got %b want 1", active); end
    vectors++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rstmid_restart_rd got %b want 1", mem_rd); end
    vectors++; if (mem_addr !== 24'd0) begin errors++; $display("FAIL rstmid_restart_addr got %0h want 0", mem_addr); end
    stop = 1'b1;
    @(negedge clk_sys);
    stop = 1'b0;
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL rstmid_stop_active got %b want 0", active); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_stop_done got %b want 0", done); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    size  = '0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    test_reset;
    test_single_byte;
    test_three_bytes;
    test_underrun;
    test_pause;
    test_stop_replay;
    test_size_zero;
    test_start_stop_same;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
